md_unit_e: RTL and testbench

//  Parametrised multi-cycle multiply/divide unit in the EX stage, beside the ALU.

---
 rtl/md_unit_e_pkg.sv | 25 ++
 rtl/md_unit_e.sv | 144 ++++++++++++++
 tb/tb_md_unit_e.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/md_unit_e_pkg.sv
// Shared opcode constants and internal types for the EX-stage multiply/divide unit.
// Opcode 0 and 13..15 are undefined and behave as no-ops when issued.
package md_unit_e_pkg;

    localparam logic [3:0] md_mult  = 4'd1;
    localparam logic [3:0] md_multu = 4'd2;
    localparam logic [3:0] md_div   = 4'd3;
    localparam logic [3:0] md_divu  = 4'd4;
    localparam logic [3:0] md_madd  = 4'd5;
    localparam logic [3:0] md_maddu = 4'd6;
    localparam logic [3:0] md_msub  = 4'd7;
    localparam logic [3:0] md_msubu = 4'd8;
    localparam logic [3:0] md_mthi  = 4'd9;
    localparam logic [3:0] md_mtlo  = 4'd10;
    localparam logic [3:0] md_mfhi  = 4'd11;
    localparam logic [3:0] md_mflo  = 4'd12;

    // How the pending value is merged into {HI,LO} at commit.
    typedef enum logic [1:0] {
        acc_set = 2'd0,
        acc_add = 2'd1,
        acc_sub = 2'd2
    } acc_kind_e;

endpackage

// File: rtl/md_unit_e.sv
// Multi-cycle multiply/divide unit with private HI/LO registers.
// Results are computed at accept and held in pending registers until the busy window ends.
module md_unit_e
    import md_unit_e_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter bit HAS_MADD    = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [3:0]       MDop,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             Cancel,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             Busy,
    output logic [WIDTH-1:0] MDresult
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   pend;
    acc_kind_e            pend_kind;
    logic                 pend_zero;

    logic                 accept;
    logic                 is_mult_class;
    logic                 is_div;
    logic                 is_signed;
    acc_kind_e            dec_kind;

    logic [2*WIDTH-1:0]   prod_u;
    logic [2*WIDTH-1:0]   prod_s;
    logic [2*WIDTH-1:0]   prod;
    logic                 div_zero;
    logic                 div_ovf;
    logic [WIDTH-1:0]     safe_b;
    logic [WIDTH-1:0]     quot;
    logic [WIDTH-1:0]     rem;
    logic [2*WIDTH-1:0]   commit_val;

    assign Busy     = (cnt != '0);
    assign accept   = Start && !Busy && !Cancel;
    assign MDresult = (MDop == md_mfhi) ? HI : LO;

    always_comb begin
        is_mult_class = 1'b0;
        is_div        = 1'b0;
        is_signed     = 1'b0;
        dec_kind      = acc_set;
        case (MDop)
            md_mult:  begin is_mult_class = 1'b1; is_signed = 1'b1; end
            md_multu: begin is_mult_class = 1'b1; end
            md_div:   begin is_div = 1'b1; is_signed = 1'b1; end
            md_divu:  begin is_div = 1'b1; end
            md_madd:  begin is_mult_class = HAS_MADD; is_signed = 1'b1; dec_kind = acc_add; end
            md_maddu: begin is_mult_class = HAS_MADD; dec_kind = acc_add; end
            md_msub:  begin is_mult_class = HAS_MADD; is_signed = 1'b1; dec_kind = acc_sub; end
            md_msubu: begin is_mult_class = HAS_MADD; dec_kind = acc_sub; end
            default:  ;
        endcase
    end

    always_comb begin
        prod_u = {{WIDTH{1'b0}}, SrcA} * {{WIDTH{1'b0}}, SrcB};
        prod_s = $signed({{WIDTH{SrcA[WIDTH-1]}}, SrcA}) * $signed({{WIDTH{SrcB[WIDTH-1]}}, SrcB});
        prod   = is_signed ? prod_s : prod_u;
    end

    // The divisor is forced to 1 for zero-divide and MIN_INT/-1 so the divider never sees them.
    always_comb begin
        div_zero = (SrcB == '0);
        div_ovf  = is_signed && (SrcA == MIN_INT) && (SrcB == {WIDTH{1'b1}});
        safe_b   = (div_zero || div_ovf) ? {{(WIDTH-1){1'b0}}, 1'b1} : SrcB;
        quot     = '0;
        rem      = '0;
        if (div_ovf) begin
            quot = MIN_INT;
            rem  = '0;
        end else if (is_signed) begin
            quot = $signed(SrcA) / $signed(safe_b);
            rem  = $signed(SrcA) % $signed(safe_b);
        end else begin
            quot = SrcA / safe_b;
            rem  = SrcA % safe_b;
        end
    end

    // Accumulating ops read HI/LO as they stand at commit, not at accept.
    always_comb begin
        commit_val = pend;
        case (pend_kind)
            acc_add: commit_val = {HI, LO} + pend;
            acc_sub: commit_val = {HI, LO} - pend;
            default: commit_val = pend;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            HI        <= '0;
            LO        <= '0;
            cnt       <= '0;
            pend      <= '0;
            pend_kind <= acc_set;
            pend_zero <= 1'b0;
        end else if (Busy) begin
            if (Cancel) begin
                cnt <= '0;
            end else begin
                cnt <= cnt - 1'b1;
                if (cnt == CW'(1) && !pend_zero) begin
                    {HI, LO} <= commit_val;
                end
            end
        end else if (accept) begin
            if (MDop == md_mthi) begin
                HI <= SrcA;
            end else if (MDop == md_mtlo) begin
                LO <= SrcA;
            end else if (is_mult_class) begin
                cnt       <= MULT_N;
                pend      <= prod;
                pend_kind <= dec_kind;
                pend_zero <= 1'b0;
            end else if (is_div) begin
                cnt       <= DIV_N;
                pend      <= {rem, quot};
                pend_kind <= acc_set;
                pend_zero <= div_zero;
            end
        end
    end

endmodule

// File: tb/tb_md_unit_e.sv
// Directed bench for md_unit_e at WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10.
// All inputs change and all outputs are sampled on the falling edge.
module tb_md_unit_e;
    import md_unit_e_pkg::*;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [3:0]  MDop;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        Cancel;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        Busy;
    logic [31:0] MDresult;

    int errors = 0;
    int checks = 0;

    md_unit_e #(
        .WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10), .HAS_MADD(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .Start(Start), .MDop(MDop),
        .SrcA(SrcA), .SrcB(SrcB), .Cancel(Cancel),
        .HI(HI), .LO(LO), .Busy(Busy), .MDresult(MDresult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called on a falling edge; returns on the falling edge of the first cycle after accept.
    task automatic issue_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        MDop  = op;
        SrcA  = a;
        SrcB  = b;
        @(negedge clk);
        Start = 1'b0;
        MDop  = md_mflo;
    endtask

    // Counts consecutive falling edges with Busy high; bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (Busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_hilo(input string name, input logic [31:0] hi_exp, input logic [31:0] lo_exp);
        checks++;
        if (HI !== hi_exp || LO !== lo_exp) begin
            errors++;
            $display("FAIL %s: got HI=%h LO=%h, expected HI=%h LO=%h", name, HI, LO, hi_exp, lo_exp);
        end
    endtask

    task automatic check_busy_len(input string name, input int n, input int n_exp);
        checks++;
        if (n !== n_exp) begin
            errors++;
            $display("FAIL %s: busy cycles got %0d, expected %0d", name, n, n_exp);
        end
    endtask

    task automatic check_busy(input string name, input logic exp);
        checks++;
        if (Busy !== exp) begin
            errors++;
            $display("FAIL %s: Busy got %b, expected %b", name, Busy, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_hilo("reset_hilo", 32'h0, 32'h0);
        check_busy("reset_busy", 1'b0);
    endtask

    task automatic test_mult();
        int n;
        issue_op(md_mult, 32'hFFFF_FFFE, 32'h3);
        wait_idle(n);
        check_busy_len("mult_len", n, 5);
        check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        issue_op(md_multu, 32'hFFFF_FFFE, 32'h3);
        wait_idle(n);
        check_busy_len("multu_len", n, 5);
        check_hilo("multu", 32'h0000_0002, 32'hFFFF_FFFA);
    endtask

    task automatic test_div();
        int n;
        issue_op(md_div, 32'hFFFF_FFF9, 32'h2);
        wait_idle(n);
        check_busy_len("div_len", n, 10);
        check_hilo("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue_op(md_divu, 32'h7, 32'h2);
        wait_idle(n);
        check_hilo("divu", 32'h1, 32'h3);
    endtask

    task automatic test_div_corner();
        int n;
        issue_op(md_mthi, 32'h11, 32'h0);
        check_busy("mthi_no_busy", 1'b0);
        issue_op(md_mtlo, 32'h22, 32'h0);
        check_hilo("mthi_mtlo", 32'h11, 32'h22);
        issue_op(md_div, 32'h5, 32'h0);
        wait_idle(n);
        check_busy_len("div0_len", n, 10);
        check_hilo("div0_keep", 32'h11, 32'h22);
        issue_op(md_div, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        check_hilo("div_ovf", 32'h0, 32'h8000_0000);
    endtask

    task automatic test_madd();
        int n;
        issue_op(md_mthi, 32'h0, 32'h0);
        issue_op(md_mtlo, 32'h1, 32'h0);
        issue_op(md_madd, 32'h2, 32'h3);
        wait_idle(n);
        check_busy_len("madd_len", n, 5);
        check_hilo("madd", 32'h0, 32'h7);
        issue_op(md_msubu, 32'h1, 32'h8);
        wait_idle(n);
        check_hilo("msubu", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    endtask

    task automatic test_ignore_and_cancel();
        int n;
        issue_op(md_mthi, 32'hAA, 32'h0);
        issue_op(md_mtlo, 32'hBB, 32'h0);
        issue_op(md_mult, 32'h4, 32'h5);
        check_busy("cancel_busy_c1", 1'b1);
        @(negedge clk);
        Start = 1'b1; MDop = md_mthi; SrcA = 32'h55;
        @(negedge clk);
        Start = 1'b0; MDop = md_mflo; Cancel = 1'b1;
        check_busy("cancel_busy_c3", 1'b1);
        check_hilo("ignored_mthi", 32'hAA, 32'hBB);
        @(negedge clk);
        Cancel = 1'b0;
        check_busy("cancel_busy_after", 1'b0);
        repeat (6) @(negedge clk);
        check_hilo("cancel_no_commit", 32'hAA, 32'hBB);
        wait_idle(n);
        check_busy_len("cancel_stays_idle", n, 0);
    endtask

    task automatic test_cancel_idle_and_undef();
        Cancel = 1'b1;
        issue_op(md_mtlo, 32'h99, 32'h0);
        check_hilo("cancel_start_mtlo", 32'hAA, 32'hBB);
        issue_op(md_mult, 32'h2, 32'h2);
        Cancel = 1'b0;
        check_busy("cancel_start_mult", 1'b0);
        Cancel = 1'b1;
        @(negedge clk);
        Cancel = 1'b0;
        check_hilo("cancel_idle", 32'hAA, 32'hBB);
        issue_op(4'h0, 32'h1, 32'h1);
        check_busy("undef0_busy", 1'b0);
        issue_op(4'hF, 32'h1, 32'h1);
        check_busy("undef15_busy", 1'b0);
        check_hilo("undef_keep", 32'hAA, 32'hBB);
    endtask

    task automatic test_back_to_back();
        int n;
        issue_op(md_mult, 32'h2, 32'h3);
        wait_idle(n);
        check_hilo("b2b_first", 32'h0, 32'h6);
        issue_op(md_multu, 32'h4, 32'h5);
        wait_idle(n);
        check_busy_len("b2b_second_len", n, 5);
        check_hilo("b2b_second", 32'h0, 32'h14);
    endtask

    task automatic test_reset_mid_div_and_mfhi();
        int n;
        issue_op(md_divu, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        check_busy("div_c4_busy", 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_busy("reset_mid_busy", 1'b0);
        check_hilo("reset_mid_hilo", 32'h0, 32'h0);
        repeat (10) @(negedge clk);
        check_hilo("reset_mid_no_commit", 32'h0, 32'h0);
        issue_op(md_mthi, 32'h1234, 32'h0);
        issue_op(md_mtlo, 32'h5678, 32'h0);
        MDop = md_mfhi;
        #1;
        checks++;
        if (MDresult !== 32'h1234) begin
            errors++;
            $display("FAIL mfhi: got %h, expected %h", MDresult, 32'h1234);
        end
        MDop = md_mflo;
        #1;
        checks++;
        if (MDresult !== 32'h5678) begin
            errors++;
            $display("FAIL mflo: got %h, expected %h", MDresult, 32'h5678);
        end
        @(negedge clk);
        issue_op(md_div, 32'd9, 32'd2);
        MDop = md_mfhi;
        #1;
        checks++;
        if (MDresult !== 32'h1234) begin
            errors++;
            $display("FAIL mfhi_while_busy: got %h, expected %h", MDresult, 32'h1234);
        end
        wait_idle(n);
        check_hilo("div_after_reset", 32'h1, 32'h4);
    endtask

    initial begin
        reset  = 1'b0;
        Start  = 1'b0;
        MDop   = md_mflo;
        SrcA   = '0;
        SrcB   = '0;
        Cancel = 1'b0;
        @(negedge clk);
        test_reset();
        test_mult();
        test_div();
        test_div_corner();
        test_madd();
        test_ignore_and_cancel();
        test_cancel_idle_and_undef();
        test_back_to_back();
        test_reset_mid_div_and_mfhi();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
